// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a single-outstanding fetch FSM feeding a DEPTH-entry
// FIFO of {pc, instr}. A redirect flushes the queue and restarts fetch at redirect_pc.
module instr_fetch_queue #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 19,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ins_valid,
  output logic [INSTR_W-1:0] ins_data,
  output logic [ADDR_W-1:0]  ins_pc,
  input  logic               ins_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] data;
  } entry_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic              drop, drop_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;
  entry_t            q [DEPTH];
  entry_t            head, push_entry;

  assign pop  = ins_valid && ins_ready && !redirect_valid;
  assign push = (state == WAIT) && mem_rvalid && !drop && !redirect_valid;

  always_comb begin
    count_nxt = count;
    if (redirect_valid)    count_nxt = '0;
    else if (push && !pop) count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    mem_req      = 1'b0;
    mem_addr     = '0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          state_nxt    = REQ;
          fetch_pc_nxt = redirect_pc;
        end else if (count < FULL) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc;
        if (mem_gnt) begin
          state_nxt = WAIT;
          if (redirect_valid) begin
            // the granted word belongs to the old stream; drop it on return
            fetch_pc_nxt = redirect_pc;
            drop_nxt     = 1'b1;
          end else begin
            fetch_pc_nxt = fetch_pc + ADDR_W'(1);
          end
        end else if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          drop_nxt  = 1'b0;
          state_nxt = (count_nxt < FULL) ? REQ : IDLE;
          if (redirect_valid) fetch_pc_nxt = redirect_pc;
        end else if (redirect_valid) begin
          drop_nxt     = 1'b1;
          fetch_pc_nxt = redirect_pc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      count    <= '0;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      drop     <= drop_nxt;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Any push is for an undropped request, so fetch_pc sits exactly one past it.
  always_comb begin
    push_entry.pc   = fetch_pc - ADDR_W'(1);
    push_entry.data = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= push_entry;
  end

  assign head      = q[rd_ptr];
  assign ins_valid = (count != '0);
  assign ins_data  = ins_valid ? head.data : '0;
  assign ins_pc    = ins_valid ? head.pc   : '0;

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, fetch-address width (1024-word instruction memory); INSTR_W, default 19, instruction width; DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_req  out  1  read request to instruction memory.
REQ-005 mem_addr  out  ADDR_W  read address; meaningful while mem_req=1.
REQ-006 mem_gnt  in  1  memory accepts the request this cycle.
REQ-007 mem_rvalid  in  1  read data valid; always at least one cycle after the matching gnt.
REQ-008 mem_rdata  in  INSTR_W  read data.
REQ-009 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  in  ADDR_W  new fetch address.
REQ-011 ins_valid  out  1  queue head holds an instruction.
REQ-012 ins_data  out  INSTR_W  head instruction.
REQ-013 ins_pc  out  ADDR_W  address of head instruction.
REQ-014 ins_ready  in  1  execute stage consumes head this cycle.

Function
REQ-015 SHALL keep fetch_pc (ADDR_W), count (log2(DEPTH)+1 bits), drop flag, and FSM states IDLE, REQ, WAIT.
REQ-016 IDLE: mem_req=0; go to REQ next cycle when count<DEPTH.
REQ-017 REQ: mem_req=1, mem_addr=fetch_pc; on mem_gnt go to WAIT and fetch_pc<=fetch_pc+1 modulo 2^ADDR_W (0x3FF wraps to 0x000).
REQ-018 WAIT: mem_req=0; on mem_rvalid push {fetch address, mem_rdata} unless drop=1; clear drop; go to REQ if count after this cycle's push/pop <DEPTH, else IDLE.
REQ-019 At most one request outstanding; mem_rvalid outside WAIT SHALL be ignored.
REQ-020 Entry to REQ only with count<=DEPTH-1, so a WAIT push never overflows.
REQ-021 ins_valid SHALL equal (count!=0); ins_data/ins_pc SHALL come from queue head and stay stable while ins_valid=1 and ins_ready=0.
REQ-022 Pop when ins_valid & ins_ready; push and pop in the same cycle leave count unchanged; ins_ready with ins_valid=0 SHALL be ignored.
REQ-023 Queue order SHALL be strict FIFO in fetch-address order.
REQ-024 redirect_valid SHALL, at the next edge, set count=0, fetch_pc=redirect_pc, and override any same-cycle push or pop.
REQ-025 Redirect in REQ without gnt: stay in REQ, mem_addr=redirect_pc next cycle.
REQ-026 Redirect in REQ coincident with gnt: go to WAIT with drop=1, fetch_pc=redirect_pc (not incremented).
REQ-027 Redirect in WAIT without rvalid: drop=1, stay WAIT; with rvalid: data discarded, go to REQ.
REQ-028 Redirect in IDLE: go to REQ next cycle.
REQ-029 Best-case throughput one instruction per two cycles; first ins_valid no earlier than the third edge after reset release (IDLE->REQ->WAIT->push).

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, force state=IDLE, fetch_pc=0, count=0, drop=0, queue head pointers=0.
REQ-031 During reset: mem_req=0, mem_addr=0, ins_valid=0, ins_data=0, ins_pc=0.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; its late rvalid is ignored (REQ-019).

Verification
REQ-033 Reset release, mem_gnt=1, rvalid one cycle after gnt, rdata=0x40000|addr, ins_ready=1 -> ins_pc 0,1,2,3 with ins_data 0x40000..0x40003, one per two cycles.
REQ-034 ins_ready=0 from reset -> four entries (pc 0-3) queued, mem_req stays 0, head holds pc 0; raise ready -> 0,1,2,3 delivered in order, fetch resumes at pc 4.
REQ-035 Redirect to 0x200 while in WAIT, rvalid two cycles later -> that data dropped, next delivered ins_pc=0x200.
REQ-036 Redirect to 0x010 coincident with rvalid and a pop, queue holding 2 entries -> ins_valid=0 next cycle, next delivered ins_pc=0x010.
REQ-037 Redirect to 0x3FF -> ins_pc sequence 0x3FF, 0x000, 0x001.
REQ-038 Assert rst asynchronously mid-WAIT with 3 entries queued -> ins_valid=0 and mem_req=0 before next edge; after release fetch restarts at pc 0; stale rvalid produces no entry.
